reg_file: RTL and testbench

//  - General-purpose register file for the single-cycle CPU: 32 x 32-bit registers.
//  - Provides two asynchronous (combinational) read ports and one synchronous write port.
//  - Sits between instruction decode (rs/rt addresses) and the ALU/writeback path.
//  - Register 0 is hard-wired to zero (MIPS convention).

---
 rtl/regfile_pkg.sv | 12 +
 rtl/regfile_read_port.sv | 31 +++
 rtl/reg_file.sv | 58 +++++
 tb/tb_reg_file.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and sizes for the CPU general-purpose register file.
package regfile_pkg;

  localparam int REG_DATA_W = 32;
  localparam int REG_ADDR_W = 5;
  localparam int REG_DEPTH  = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [REG_DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port of the register file: address mux, r0 override
// and, when REGFILE_BYPASS_EN is defined, write-through forwarding from the
// write port in the same cycle.
module regfile_read_port
  import regfile_pkg::*;
(
  input  reg_data_t regs [REG_DEPTH],
  input  reg_addr_t addr,
`ifdef REGFILE_BYPASS_EN
  input  logic      wr_en,
  input  reg_addr_t wr_addr,
  input  reg_data_t wr_data,
`endif
  output reg_data_t data
);

  // Select the addressed register; r0 is forced to zero regardless of storage.
  always_comb begin
    data = regs[addr];
`ifdef REGFILE_BYPASS_EN
    // wr_en already excludes r0 and reset, so r0 can never be forwarded.
    if (wr_en && (wr_addr == addr)) begin
      data = wr_data;
    end
`endif
    if (addr == REG_ZERO) begin
      data = '0;
    end
  end

endmodule

// File: rtl/reg_file.sv
// 32 x 32-bit register file: two combinational read ports, one synchronous
// write port, r0 hard-wired to zero, asynchronous active-low reset.
// Optional feature: define REGFILE_BYPASS_EN to forward the write data to a
// read port that addresses the register being written in the same cycle.
module reg_file
  import regfile_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  readReg1,
  input  logic [4:0]  readReg2,
  input  logic [4:0]  writeReg,
  input  logic [31:0] writeData,
  input  logic        isWreg,
  output logic [31:0] readData1,
  output logic [31:0] readData2
);

  reg_data_t regs [REG_DEPTH];
  logic      wr_active;

  // A write is only meaningful out of reset and to a non-zero register.
  assign wr_active = isWreg && rst_n && (writeReg != REG_ZERO);

  // Storage: cleared asynchronously, written on the rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_active) begin
      regs[writeReg] <= writeData;
    end
  end

  regfile_read_port u_read_port1 (
    .regs    (regs),
    .addr    (readReg1),
`ifdef REGFILE_BYPASS_EN
    .wr_en   (wr_active),
    .wr_addr (writeReg),
    .wr_data (writeData),
`endif
    .data    (readData1)
  );

  regfile_read_port u_read_port2 (
    .regs    (regs),
    .addr    (readReg2),
`ifdef REGFILE_BYPASS_EN
    .wr_en   (wr_active),
    .wr_addr (writeReg),
    .wr_data (writeData),
`endif
    .data    (readData2)
  );

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: table of single-cycle vectors plus
// hand-written sequences for reset, read-during-write and r0 corner cases.
module tb_reg_file;

  logic        clk;
  logic        rst_n;
  logic [4:0]  readReg1;
  logic [4:0]  readReg2;
  logic [4:0]  writeReg;
  logic [31:0] writeData;
  logic        isWreg;
  logic [31:0] readData1;
  logic [31:0] readData2;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0]  rr1;
    logic [4:0]  rr2;
    logic        we;
    logic [4:0]  wr;
    logic [31:0] wd;
    logic [31:0] exp1;
    logic [31:0] exp2;
  } vec_t;

  typedef struct {
    logic [31:0] exp1;
    logic [31:0] exp2;
    string       name;
  } sb_t;

  sb_t  sb_q[$];
  vec_t vecs[11];

  reg_file dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .readReg1  (readReg1),
    .readReg2  (readReg2),
    .writeReg  (writeReg),
    .writeData (writeData),
    .isWreg    (isWreg),
    .readData1 (readData1),
    .readData2 (readData2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push_exp(input logic [31:0] e1, input logic [31:0] e2, input string name);
    sb_t s;
    s.exp1 = e1;
    s.exp2 = e2;
    s.name = name;
    sb_q.push_back(s);
  endtask

  task automatic pop_cmp();
    sb_t s;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: no expected entry queued");
      return;
    end
    s = sb_q.pop_front();
    checks++;
    if (readData1 !== s.exp1 || readData2 !== s.exp2) begin
      errors++;
      $display("FAIL %s: readData1=%h readData2=%h expected %h %h",
               s.name, readData1, readData2, s.exp1, s.exp2);
    end
  endtask

  task automatic drive(input logic [4:0] rr1, input logic [4:0] rr2, input logic we,
                       input logic [4:0] wr, input logic [31:0] wd);
    readReg1  = rr1;
    readReg2  = rr2;
    isWreg    = we;
    writeReg  = wr;
    writeData = wd;
  endtask

  initial begin
    logic [31:0] rdw_pre;

    // rr1, rr2, we, wr, wd, exp1, exp2 (values seen just after the edge)
    vecs[0]  = '{5'd1,  5'd31, 1'b0, 5'd0,  32'h0,        32'h0,        32'h0};
    vecs[1]  = '{5'd0,  5'd0,  1'b1, 5'd1,  32'h000000D1, 32'h0,        32'h0};
    vecs[2]  = '{5'd1,  5'd1,  1'b1, 5'd2,  32'h000000D2, 32'h000000D1, 32'h000000D1};
    vecs[3]  = '{5'd2,  5'd2,  1'b0, 5'd0,  32'h0,        32'h000000D2, 32'h000000D2};
    vecs[4]  = '{5'd1,  5'd2,  1'b0, 5'd1,  32'hDEADBEEF, 32'h000000D1, 32'h000000D2};
    vecs[5]  = '{5'd5,  5'd6,  1'b1, 5'd6,  32'h000000D3, 32'h0,        32'h000000D3};
    vecs[6]  = '{5'd0,  5'd0,  1'b1, 5'd0,  32'hFFFFFFFF, 32'h0,        32'h0};
    vecs[7]  = '{5'd1,  5'd0,  1'b0, 5'd0,  32'h0,        32'h000000D1, 32'h0};
    vecs[8]  = '{5'd31, 5'd30, 1'b1, 5'd31, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'h0};
    vecs[9]  = '{5'd1,  5'd2,  1'b1, 5'd1,  32'h12345678, 32'h12345678, 32'h000000D2};
    vecs[10] = '{5'd6,  5'd31, 1'b0, 5'd0,  32'h0,        32'h000000D3, 32'hA5A5A5A5};

    // Start deasserted so the first reset produces a real falling edge.
    rst_n = 1'b1;
    drive(5'd1, 5'd31, 1'b0, 5'd0, 32'h0);
    #1 rst_n = 1'b0;
    #1;
    push_exp(32'h0, 32'h0, "reset_state");
    pop_cmp();
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      drive(vecs[i].rr1, vecs[i].rr2, vecs[i].we, vecs[i].wr, vecs[i].wd);
      push_exp(vecs[i].exp1, vecs[i].exp2, $sformatf("vec%0d", i));
      @(posedge clk);
      #1 pop_cmp();
    end

    // Read-during-write on r6: before the edge, forwarded or old value.
`ifdef REGFILE_BYPASS_EN
    rdw_pre = 32'h00000055;
`else
    rdw_pre = 32'h000000D3;
`endif
    @(negedge clk);
    drive(5'd6, 5'd6, 1'b1, 5'd6, 32'h00000055);
    push_exp(rdw_pre, rdw_pre, "rdw_pre_edge");
    #1 pop_cmp();
    push_exp(32'h00000055, 32'h00000055, "rdw_post_edge");
    @(posedge clk);
    #1 pop_cmp();

    // Other port on a different register is unaffected by the write.
    @(negedge clk);
    drive(5'd2, 5'd7, 1'b1, 5'd7, 32'h00000077);
`ifdef REGFILE_BYPASS_EN
    push_exp(32'h000000D2, 32'h00000077, "rdw_other_port");
`else
    push_exp(32'h000000D2, 32'h0, "rdw_other_port");
`endif
    #1 pop_cmp();

    // r0 write in flight must never be forwarded.
    @(negedge clk);
    drive(5'd0, 5'd0, 1'b1, 5'd0, 32'hFFFFFFFF);
    push_exp(32'h0, 32'h0, "r0_pre_edge");
    #1 pop_cmp();
    push_exp(32'h0, 32'h0, "r0_post_edge");
    @(posedge clk);
    #1 pop_cmp();

    // Reset mid-cycle with a write pending: clears at once, write is lost.
    @(negedge clk);
    drive(5'd1, 5'd31, 1'b1, 5'd1, 32'h0000BEEF);
    #2 rst_n = 1'b0;
    #1;
    push_exp(32'h0, 32'h0, "reset_mid_cycle");
    pop_cmp();
    push_exp(32'h0, 32'h0, "reset_write_lost");
    @(posedge clk);
    #1 pop_cmp();
    @(negedge clk);
    drive(5'd6, 5'd2, 1'b0, 5'd0, 32'h0);
    rst_n = 1'b1;
    push_exp(32'h0, 32'h0, "after_reset_cleared");
    @(posedge clk);
    #1 pop_cmp();

    // Writes work again after reset release.
    @(negedge clk);
    drive(5'd9, 5'd9, 1'b1, 5'd9, 32'hCAFEF00D);
    push_exp(32'hCAFEF00D, 32'hCAFEF00D, "write_after_reset");
    @(posedge clk);
    #1 pop_cmp();

    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: %0d entries remaining, expected 0", sb_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
